// File: rtl/rate_enable_gen.sv
// Paced read-enable generator: debounced pushbuttons select one of NUM_RATES
// divider rates (x4 apart), toggle pause, and single-step while paused.
module rate_enable_gen #(
  parameter int BASE_DIV     = 100_000_000,
  parameter int NUM_RATES    = 4,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btnU,
  input  logic btnD,
  input  logic btnC,
  input  logic btnR,
  output logic enable,
  output logic [((NUM_RATES > 1) ? $clog2(NUM_RATES) : 1)-1:0] rate_sel,
  output logic paused
);

  localparam int RW    = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1;
  localparam int CNT_W = $clog2(BASE_DIV + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [RW-1:0]   MAX_RATE = RW'(NUM_RATES - 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

  // Terminal count for rate k: (BASE_DIV >> 2k) - 1.
  function automatic logic [CNT_W-1:0] rate_last(input logic [RW-1:0] k);
    return CNT_W'((BASE_DIV >> (2 * int'(k))) - 1);
  endfunction

  // Button order: 0 = up, 1 = down, 2 = pause, 3 = step.
  logic [3:0]      raw;
  logic [3:0]      sync_p0;
  logic [3:0]      sync_p1;
  logic [3:0]      level;
  logic [3:0]      press;
  logic [DB_W-1:0] db_cnt [4];

  logic [CNT_W-1:0] cnt;
  logic             up_go;
  logic             dn_go;
  logic             step_go;
  logic             pause_go;
  logic             terminal;

  assign raw = {btnR, btnC, btnD, btnU};

  // Stage p0/p1: two-flop synchronizer, then debounced level and press pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      level   <= '0;
      press   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync_p1[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync_p1[i];
          db_cnt[i] <= '0;
          press[i]  <= sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign up_go    = press[0] & ~press[1] & (rate_sel != MAX_RATE);
  assign dn_go    = press[1] & ~press[0] & (rate_sel != '0);
  assign step_go  = paused & press[3];
  assign pause_go = ~paused & press[2];
  assign terminal = (cnt == rate_last(rate_sel));

  // Stage p2: rate/pause state and divider; every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rate_sel <= '0;
      paused   <= 1'b0;
      cnt      <= '0;
      enable   <= 1'b0;
    end else begin
      paused <= paused ^ press[2];
      if (up_go) begin
        rate_sel <= rate_sel + RW'(1);
      end else if (dn_go) begin
        rate_sel <= rate_sel - RW'(1);
      end
      if (up_go || dn_go) begin
        cnt    <= '0;
        enable <= step_go;
      end else if (step_go) begin
        enable <= 1'b1;
      end else if (paused || pause_go) begin
        enable <= 1'b0;
      end else if (terminal) begin
        cnt    <= '0;
        enable <= 1'b1;
      end else begin
        cnt    <= cnt + CNT_W'(1);
        enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rate_enable_gen.sv
// Directed bench for rate_enable_gen with BASE_DIV=64, NUM_RATES=4,
// DEBOUNCE_CYC=4 (divisors 64/16/4/1, press takes effect 7 cycles after raw rise).
module tb_rate_enable_gen;

  localparam int BASE_DIV     = 64;
  localparam int NUM_RATES    = 4;
  localparam int DEBOUNCE_CYC = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       btnU  = 1'b0;
  logic       btnD  = 1'b0;
  logic       btnC  = 1'b0;
  logic       btnR  = 1'b0;
  logic       enable;
  logic [1:0] rate_sel;
  logic       paused;

  int n_checks = 0;
  int n_pass   = 0;

  rate_enable_gen #(
    .BASE_DIV(BASE_DIV),
    .NUM_RATES(NUM_RATES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btnU(btnU),
    .btnD(btnD),
    .btnC(btnC),
    .btnR(btnR),
    .enable(enable),
    .rate_sel(rate_sel),
    .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles until the next enable; -1 if none within 200 cycles.
  task automatic wait_enable(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      if (enable === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btnU = v;
      1: btnD = v;
      2: btnC = v;
      default: btnR = v;
    endcase
  endtask

  // Clean press: effect lands 7 cycles after rise; returns 14 cycles after rise.
  task automatic press_btn(input int idx);
    set_btn(idx, 1'b1);
    tick(7);
    set_btn(idx, 1'b0);
    tick(7);
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    tick(3);
    n_checks++;
    if ({enable, rate_sel, paused} !== 4'b0000)
      $display("FAIL reset_outputs: got %b expected 0000", {enable, rate_sel, paused});
    else n_pass++;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_enable(n);
      n_checks++;
      if (n !== 64) $display("FAIL reset_period%0d: got %0d expected 64", k, n);
      else n_pass++;
    end
    n_checks++;
    if ({rate_sel, paused} !== 3'b000)
      $display("FAIL reset_state: got rate=%0d paused=%b expected 0/0", rate_sel, paused);
    else n_pass++;
  endtask

  task automatic test_speed_up;
    int n;
    int first [3] = '{9, 1, 1};
    int per   [3] = '{16, 4, 1};
    for (int k = 0; k < 3; k++) begin
      press_btn(0);
      n_checks++;
      if (rate_sel !== 2'(k + 1)) $display("FAIL up_rate%0d: got %0d expected %0d", k, rate_sel, k + 1);
      else n_pass++;
      wait_enable(n);
      n_checks++;
      if (n !== first[k]) $display("FAIL up_first%0d: got %0d expected %0d", k, n, first[k]);
      else n_pass++;
      wait_enable(n);
      n_checks++;
      if (n !== per[k]) $display("FAIL up_period%0d: got %0d expected %0d", k, n, per[k]);
      else n_pass++;
    end
    press_btn(0);
    n_checks++;
    if (rate_sel !== 2'd3) $display("FAIL up_saturate: got %0d expected 3", rate_sel);
    else n_pass++;
    n_checks++;
    if (enable !== 1'b1) $display("FAIL up_sat_enable: got %b expected 1", enable);
    else n_pass++;
  endtask

  task automatic test_speed_down;
    int n;
    int first [3] = '{1, 9, 57};
    int per   [3] = '{4, 16, 64};
    for (int k = 0; k < 3; k++) begin
      press_btn(1);
      n_checks++;
      if (rate_sel !== 2'(2 - k)) $display("FAIL down_rate%0d: got %0d expected %0d", k, rate_sel, 2 - k);
      else n_pass++;
      wait_enable(n);
      n_checks++;
      if (n !== first[k]) $display("FAIL down_first%0d: got %0d expected %0d", k, n, first[k]);
      else n_pass++;
      wait_enable(n);
      n_checks++;
      if (n !== per[k]) $display("FAIL down_period%0d: got %0d expected %0d", k, n, per[k]);
      else n_pass++;
    end
    press_btn(1);
    n_checks++;
    if (rate_sel !== 2'd0) $display("FAIL down_saturate: got %0d expected 0", rate_sel);
    else n_pass++;
    wait_enable(n);
    n_checks++;
    if (n !== 50) $display("FAIL down_sat_phase: got %0d expected 50", n);
    else n_pass++;
  endtask

  task automatic test_pause;
    int n;
    int en_cnt;
    // Called on an enable cycle (cnt=0): rising 4 cycles later freezes cnt at 10.
    tick(4);
    btnC = 1'b1;
    tick(7);
    n_checks++;
    if ({paused, enable} !== 2'b10) $display("FAIL pause_enter: got paused/en=%b expected 10", {paused, enable});
    else n_pass++;
    btnC = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      en_cnt += int'(enable);
    end
    n_checks++;
    if (en_cnt !== 0 || paused !== 1'b1)
      $display("FAIL pause_hold: got enables=%0d paused=%b expected 0/1", en_cnt, paused);
    else n_pass++;
    btnC = 1'b1;
    tick(7);
    n_checks++;
    if (paused !== 1'b0) $display("FAIL pause_resume: got %b expected 0", paused);
    else n_pass++;
    btnC = 1'b0;
    wait_enable(n);
    n_checks++;
    if (n !== 54) $display("FAIL pause_resume_phase: got %0d expected 54", n);
    else n_pass++;
    wait_enable(n);
    n_checks++;
    if (n !== 64) $display("FAIL pause_period: got %0d expected 64", n);
    else n_pass++;
    // Pause lands exactly where terminal count would have fired.
    tick(57);
    btnC = 1'b1;
    tick(7);
    n_checks++;
    if ({paused, enable} !== 2'b10) $display("FAIL pause_at_terminal: got paused/en=%b expected 10", {paused, enable});
    else n_pass++;
    btnC = 1'b0;
    tick(10);
    btnC = 1'b1;
    tick(7);
    btnC = 1'b0;
    wait_enable(n);
    n_checks++;
    if (n !== 1) $display("FAIL pause_terminal_resume: got %0d expected 1", n);
    else n_pass++;
  endtask

  task automatic test_step;
    int n;
    int en_cnt;
    logic e7;
    tick(4);
    press_btn(2);
    n_checks++;
    if (paused !== 1'b1) $display("FAIL step_pause: got %b expected 1", paused);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      btnR   = 1'b1;
      en_cnt = 0;
      e7     = 1'b0;
      for (int j = 1; j <= 14; j++) begin
        tick(1);
        en_cnt += int'(enable);
        if (j == 7) begin
          e7   = enable;
          btnR = 1'b0;
        end
      end
      n_checks++;
      if (e7 !== 1'b1 || en_cnt !== 1)
        $display("FAIL step%0d: got en@7=%b count=%0d expected 1/1", k, e7, en_cnt);
      else n_pass++;
    end
    btnC = 1'b1;
    tick(7);
    btnC = 1'b0;
    wait_enable(n);
    n_checks++;
    if (n !== 54) $display("FAIL step_cnt_kept: got %0d expected 54", n);
    else n_pass++;
    en_cnt = 0;
    btnR = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      tick(1);
      en_cnt += int'(enable);
      if (j == 7) btnR = 1'b0;
    end
    n_checks++;
    if (en_cnt !== 0) $display("FAIL step_running: got %0d extra enables expected 0", en_cnt);
    else n_pass++;
    wait_enable(n);
    n_checks++;
    if (n !== 50) $display("FAIL step_running_phase: got %0d expected 50", n);
    else n_pass++;
    tick(4);
    press_btn(2);
    btnR = 1'b1;
    btnC = 1'b1;
    tick(7);
    n_checks++;
    if ({enable, paused} !== 2'b10) $display("FAIL step_and_resume: got en/paused=%b expected 10", {enable, paused});
    else n_pass++;
    btnR = 1'b0;
    btnC = 1'b0;
    wait_enable(n);
    n_checks++;
    if (n !== 54) $display("FAIL step_resume_phase: got %0d expected 54", n);
    else n_pass++;
  endtask

  task automatic test_debounce;
    int n;
    btnU = 1'b1;
    tick(3);
    btnU = 1'b0;
    tick(10);
    n_checks++;
    if (rate_sel !== 2'd0) $display("FAIL glitch: got rate %0d expected 0", rate_sel);
    else n_pass++;
    btnU = 1'b1;
    btnD = 1'b1;
    tick(7);
    n_checks++;
    if (rate_sel !== 2'd0) $display("FAIL up_down_same: got rate %0d expected 0", rate_sel);
    else n_pass++;
    btnU = 1'b0;
    btnD = 1'b0;
    tick(7);
    btnU  = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(6);
    n_checks++;
    if (rate_sel !== 2'd0) $display("FAIL held_reset_early: got rate %0d expected 0", rate_sel);
    else n_pass++;
    tick(1);
    n_checks++;
    if (rate_sel !== 2'd1) $display("FAIL held_reset_press: got rate %0d expected 1", rate_sel);
    else n_pass++;
    btnU = 1'b0;
    tick(7);
  endtask

  task automatic test_reset_mid;
    int n;
    press_btn(2);
    tick(5);
    reset = 1'b1;
    tick(1);
    n_checks++;
    if ({enable, rate_sel, paused} !== 4'b0000)
      $display("FAIL reset_mid: got %b expected 0000", {enable, rate_sel, paused});
    else n_pass++;
    tick(2);
    reset = 1'b0;
    wait_enable(n);
    n_checks++;
    if (n !== 64) $display("FAIL reset_mid_first: got %0d expected 64", n);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_speed_up();
    test_speed_down();
    test_pause();
    test_step();
    test_debounce();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
